// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Decode-stage register file with synchronous reset, write-to-read bypass
//   and a per-register busy scoreboard for long-latency producers. Reads of
//   PC_REG return pcAlias; that index is never written and never busy.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   writeEnable/Addr/Data commit port (also retires the busy bit)
//   busySet/busySetAddr  mark a register as awaiting a producer
//   pcAlias              value returned for reads of PC_REG
//   readAddr             NUM_READ packed read addresses (AW bits each)
//   readData             NUM_READ packed read values (DATA_W bits each)
//   readBusy             per-port operand-not-ready flag
//   busyVec              registered busy bits, bit n = register n
//   pendingCount         popcount of busyVec
module regfile_scoreboard #(
    parameter int                DATA_W    = 32,
    parameter int                NUM_REGS  = 16,
    parameter int                NUM_READ  = 2,
    parameter int                PC_REG    = 15,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    localparam int               AW        = $clog2(NUM_REGS),
    localparam int               CW        = $clog2(NUM_REGS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       writeEnable,
    input  logic [AW-1:0]              writeAddr,
    input  logic [DATA_W-1:0]          writeData,
    input  logic                       busySet,
    input  logic [AW-1:0]              busySetAddr,
    input  logic [DATA_W-1:0]          pcAlias,
    input  logic [NUM_READ*AW-1:0]     readAddr,
    output logic [NUM_READ*DATA_W-1:0] readData,
    output logic [NUM_READ-1:0]        readBusy,
    output logic [NUM_REGS-1:0]        busyVec,
    output logic [CW-1:0]              pendingCount
);

    localparam logic [AW-1:0] PC_IDX = AW'(PC_REG);
    localparam logic [AW:0]   NREGS  = (AW + 1)'(NUM_REGS);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                wr_vld, set_vld;
    logic [CW-1:0]       cnt;

    // Address range check is widened by one bit so non-power-of-two
    // register counts reject the unused top indices.
    assign wr_vld  = writeEnable && (writeAddr != PC_IDX) && ({1'b0, writeAddr} < NREGS);
    assign set_vld = busySet && (busySetAddr != PC_IDX) && ({1'b0, busySetAddr} < NREGS);

    // Retire first, then set: a new producer on the same index supersedes
    // the one retiring this cycle.
    always_comb begin
        busy_d = busy_q;
        for (int n = 0; n < NUM_REGS; n++) begin
            if (wr_vld && writeAddr == AW'(n))    busy_d[n] = 1'b0;
            if (set_vld && busySetAddr == AW'(n)) busy_d[n] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= RESET_VAL;
            busy_q <= '0;
        end else begin
            for (int n = 0; n < NUM_REGS; n++)
                if (wr_vld && writeAddr == AW'(n)) regs_q[n] <= writeData;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        cnt = '0;
        for (int n = 0; n < NUM_REGS; n++) cnt = cnt + CW'(busy_q[n]);
    end

    assign busyVec      = busy_q;
    assign pendingCount = cnt;

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] rd;
        logic              rb;

        assign ra = readAddr[p*AW +: AW];

        // Priority: PC alias, out-of-range, bypass, storage. A bypassed
        // operand is by definition available, so it never reports busy.
        always_comb begin
            rd = '0;
            rb = 1'b0;
            if (ra == PC_IDX) begin
                rd = pcAlias;
            end else if ({1'b0, ra} < NREGS) begin
                if (wr_vld && writeAddr == ra) begin
                    rd = writeData;
                end else begin
                    for (int n = 0; n < NUM_REGS; n++) begin
                        if (ra == AW'(n)) begin
                            rd = regs_q[n];
                            rb = busy_q[n];
                        end
                    end
                end
            end
        end

        assign readData[p*DATA_W +: DATA_W] = rd;
        assign readBusy[p]                  = rb;
    end

endmodule
